vga_image_scanner: RTL

- Upstream/downstream companion of the 400x400 RGB image ROM (24-bit word per pixel, 1-clk registered read).
- Generates 640x480@60 VGA timing and drives the ROM address for a centred 400x400 window.
- Realigns sync/blank with the ROM read latency and outputs 8:8:8 RGB; outside the window it outputs black.
- Sits between the image ROM and the board VGA DAC pins.

---
 rtl/vga_pkg.sv | 22 ++
 rtl/vga_timing_gen.sv | 69 ++++++
 rtl/vga_image_scanner.sv | 133 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and the RGB pixel type shared by the scanner.
package vga_pkg;

  localparam int unsigned H_ACTIVE = 640;
  localparam int unsigned H_FP     = 16;
  localparam int unsigned H_SYNC   = 96;
  localparam int unsigned H_BP     = 48;
  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE = 480;
  localparam int unsigned V_FP     = 10;
  localparam int unsigned V_SYNC   = 2;
  localparam int unsigned V_BP     = 33;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel tick divider, horizontal/vertical counters and raw (unregistered) sync/active flags.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_tick,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_act,
  output logic       vs_act,
  output logic       active,
  output logic       frame_end
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic             run;
  logic [DIV_W-1:0] div;

  // Divider: held at 0 for the first clk after reset so the first tick lands on the following clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      run <= 1'b0;
      div <= '0;
    end else begin
      run <= 1'b1;
      if (run) div <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
    end
  end

  assign pix_tick = run && (div == '0);

  // Raster counters advance once per pixel tick; the vertical counter steps on line wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  // Raw flags for the pixel the counters currently show.
  always_comb begin
    hs_act    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    vs_act    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    active    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
  end

endmodule

// File: rtl/vga_image_scanner.sv
// Scans a centred image window out of a registered-read ROM and drives VGA sync/blank/RGB,
// with sync and blank delayed to line up with the ROM read latency.
module vga_image_scanner
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned IMG_W   = 400,
  parameter int unsigned IMG_H   = 400,
  parameter int unsigned X0      = 120,
  parameter int unsigned Y0      = 40
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rom_addr,
  input  logic [23:0] rom_data,
  output logic        pix_tick,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b
);

  localparam int unsigned N_PIX  = IMG_W * IMG_H;
  localparam int unsigned ADDR_W = (N_PIX > 1) ? $clog2(N_PIX) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_PIX - 1);

  localparam logic [9:0] WX0 = 10'(X0);
  localparam logic [9:0] WX1 = 10'(X0 + IMG_W);
  localparam logic [9:0] WY0 = 10'(Y0);
  localparam logic [9:0] WY1 = 10'(Y0 + IMG_H);

  logic [9:0]        h_cnt, v_cnt;
  logic              hs_act, vs_act, active, frame_end;
  logic              in_win;
  logic [ADDR_W-1:0] addr;
  logic              win_d1, hs_d1, vs_d1, act_d1;
  logic              tick_d;
  rgb_t              rom_q;
  rgb_t              rom_pix;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_tick  (pix_tick),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .hs_act    (hs_act),
    .vs_act    (vs_act),
    .active    (active),
    .frame_end (frame_end)
  );

  // Window membership of the pixel the counters currently show.
  always_comb begin
    in_win = (h_cnt >= WX0) && (h_cnt < WX1) && (v_cnt >= WY0) && (v_cnt < WY1);
  end

  // Linear ROM address: steps through the window in raster order, held on the last pixel
  // until the frame wrap clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
    end else begin
      assert (addr <= ADDR_LAST);
      if (pix_tick) begin
        if (frame_end) addr <= '0;
        else if (in_win && (addr != ADDR_LAST)) addr <= addr + ADDR_W'(1);
      end
    end
  end

  assign rom_addr = 32'(addr);

  // Stage 1: capture window/sync/active flags of the pixel whose address is being read.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_d1 <= 1'b0;
      hs_d1  <= 1'b0;
      vs_d1  <= 1'b0;
      act_d1 <= 1'b0;
    end else if (pix_tick) begin
      win_d1 <= in_win;
      hs_d1  <= hs_act;
      vs_d1  <= vs_act;
      act_d1 <= active;
    end
  end

  // ROM word hold: with CLK_DIV>1 the address moves on before stage 2 samples, and the ROM
  // would re-read the next pixel on an intermediate clk, so the word is latched one clk after
  // the tick and forwarded directly when stage 2 is that very clk (CLK_DIV=1).
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_d <= 1'b0;
      rom_q  <= '0;
    end else begin
      tick_d <= pix_tick;
      if (tick_d) rom_q <= rgb_t'(rom_data);
    end
  end

  assign rom_pix = tick_d ? rgb_t'(rom_data) : rom_q;

  // Stage 2: registered VGA outputs; black outside the window and whenever blanked.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank_n <= 1'b0;
      r       <= '0;
      g       <= '0;
      b       <= '0;
    end else if (pix_tick) begin
      hsync   <= ~hs_d1;
      vsync   <= ~vs_d1;
      blank_n <= act_d1;
      if (win_d1 && act_d1) begin
        r <= rom_pix.r;
        g <= rom_pix.g;
        b <= rom_pix.b;
      end else begin
        r <= '0;
        g <= '0;
        b <= '0;
      end
    end
  end

endmodule
